// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the inst_req/addr_ok/data_ok
// request side, and hands {valid, pc, cancelled, exception} slots to decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC        = 32'hbfc00000,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic        cancelled_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o
);

    localparam int unsigned OW       = 3;
    localparam logic [4:0]  EXC_ADEL = 5'h04;

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_EXC} state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [31:0]     slot_pc_q, slot_pc_d;
    logic            canc_q, canc_d;
    logic            exc_q, exc_d;
    logic [4:0]      code_q, code_d;
    logic [OW-1:0]   outst_q, outst_d;
    logic            buf_v_q, buf_v_d;
    logic            buf_exc_q, buf_exc_d;
    logic [31:0]     buf_tgt_q, buf_tgt_d;
    logic            acc_q, acc_d;

    logic            req_c;
    logic            hs;
    logic            redir;
    logic [31:0]     redir_tgt;
    logic            buf_v_n;
    logic            buf_exc_n;
    logic [31:0]     buf_tgt_n;
    logic            dec;

    assign inst_addr = pc_q;
    assign inst_req  = req_c;
    assign hs        = req_c & inst_addr_ok;
    assign redir     = br_valid | exc_redirect;
    assign redir_tgt = exc_redirect ? exc_target : br_target;
    assign dec       = inst_data_ok && (outst_q != '0);

    // Redirect buffer as it stands including this cycle's pulse; exceptions are sticky over branches.
    assign buf_v_n   = buf_v_q | redir;
    assign buf_exc_n = buf_exc_q | exc_redirect;
    assign buf_tgt_n = exc_redirect                ? exc_target :
                       (br_valid && !buf_exc_q)     ? br_target  : buf_tgt_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        slot_pc_d = slot_pc_q;
        canc_d    = canc_q;
        exc_d     = exc_q;
        code_d    = code_q;
        buf_v_d   = buf_v_q;
        buf_exc_d = buf_exc_q;
        buf_tgt_d = buf_tgt_q;
        acc_d     = acc_q;
        req_c     = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                req_c = resetn && ready_i && (pc_q[1:0] == 2'b00) &&
                        (outst_q < OW'(MAX_OUTSTANDING)) && !redir;
                if (redir) begin
                    pc_d = redir_tgt;
                    if (ready_i)      valid_d = 1'b0;
                    else if (valid_q) canc_d  = 1'b1;
                end else if (ready_i) begin
                    if (pc_q[1:0] != 2'b00) begin
                        valid_d   = 1'b1;
                        slot_pc_d = pc_q;
                        canc_d    = 1'b0;
                        exc_d     = 1'b1;
                        code_d    = EXC_ADEL;
                        state_d   = S_EXC;
                    end else if (hs) begin
                        valid_d   = 1'b1;
                        slot_pc_d = pc_q;
                        canc_d    = 1'b0;
                        exc_d     = 1'b0;
                        code_d    = 5'h00;
                        pc_d      = pc_q + 32'd4;
                    end else begin
                        valid_d = 1'b0;
                        if (req_c) state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Address stays put until accepted; afterwards wait for decode to take the slot.
                req_c     = resetn && !acc_q;
                buf_v_d   = buf_v_n;
                buf_exc_d = buf_exc_n;
                buf_tgt_d = buf_tgt_n;
                if ((hs || acc_q) && ready_i) begin
                    valid_d   = 1'b1;
                    slot_pc_d = pc_q;
                    canc_d    = buf_v_n;
                    exc_d     = 1'b0;
                    code_d    = 5'h00;
                    pc_d      = buf_v_n ? buf_tgt_n : pc_q + 32'd4;
                    buf_v_d   = 1'b0;
                    buf_exc_d = 1'b0;
                    acc_d     = 1'b0;
                    state_d   = S_FETCH;
                end else if (hs) begin
                    acc_d = 1'b1;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                end
            end
            S_EXC: begin
                if (ready_i) valid_d = 1'b0;
                if (redir) begin
                    pc_d    = redir_tgt;
                    exc_d   = 1'b0;
                    code_d  = 5'h00;
                    if (valid_q && !ready_i) canc_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        outst_d = outst_q;
        if (hs && !dec)      outst_d = outst_q + OW'(1);
        else if (!hs && dec) outst_d = outst_q - OW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            slot_pc_q <= 32'h0;
            canc_q    <= 1'b0;
            exc_q     <= 1'b0;
            code_q    <= 5'h00;
            outst_q   <= '0;
            buf_v_q   <= 1'b0;
            buf_exc_q <= 1'b0;
            buf_tgt_q <= 32'h0;
            acc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            slot_pc_q <= slot_pc_d;
            canc_q    <= canc_d;
            exc_q     <= exc_d;
            code_q    <= code_d;
            outst_q   <= outst_d;
            buf_v_q   <= buf_v_d;
            buf_exc_q <= buf_exc_d;
            buf_tgt_q <= buf_tgt_d;
            acc_q     <= acc_d;
        end
    end

    assign valid_o     = valid_q;
    assign pc_o        = slot_pc_q;
    assign cancelled_o = canc_q;
    assign exc_o       = exc_q;
    assign exccode_o   = code_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scenario bench for fetch_stage with an expected-slot scoreboard and a
// data_ok protocol tracker.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        br_valid;
    logic [31:0] br_target;
    logic        exc_redirect;
    logic [31:0] exc_target;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic        cancelled_o;
    logic        exc_o;
    logic [4:0]  exccode_o;

    int total = 0;
    int bad   = 0;
    int model_outst = 0;
    logic [31:0] sb_pc[$];
    logic        sb_canc[$];

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'hbfc00000), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .br_valid(br_valid), .br_target(br_target),
        .exc_redirect(exc_redirect), .exc_target(exc_target),
        .ready_i(ready_i), .valid_o(valid_o), .pc_o(pc_o),
        .cancelled_o(cancelled_o), .exc_o(exc_o), .exccode_o(exccode_o)
    );

    // Apply one cycle of inputs just after the clock edge and let them settle.
    task automatic drive(input logic rdy, input logic aok, input logic dok,
                         input logic br, input logic [31:0] bt,
                         input logic ex, input logic [31:0] et);
        ready_i      = rdy;
        inst_addr_ok = aok;
        inst_data_ok = dok;
        br_valid     = br;
        br_target    = bt;
        exc_redirect = ex;
        exc_target   = et;
        #1;
    endtask

    // Advance one clock; track outstanding requests and flag data_ok with nothing in flight.
    task automatic tick();
        if (!resetn) begin
            model_outst = 0;
        end else begin
            if (inst_data_ok) begin
                total++;
                if (model_outst == 0) begin
                    $display("FAIL data_ok_protocol outstanding=%0d required>0", model_outst);
                    bad++;
                end
            end
            model_outst = model_outst + ((inst_req && inst_addr_ok) ? 1 : 0)
                                      - ((inst_data_ok && model_outst > 0) ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        tick();
        tick();
        total++; if (inst_req !== 1'b0) begin $display("FAIL reset_req got=%b want=0", inst_req); bad++; end
        total++; if (inst_addr !== 32'hbfc00000) begin $display("FAIL reset_addr got=%h want=bfc00000", inst_addr); bad++; end
        total++; if (valid_o !== 1'b0 || pc_o !== 32'h0 || cancelled_o !== 1'b0 || exc_o !== 1'b0 || exccode_o !== 5'h0) begin
            $display("FAIL reset_slot got v=%b pc=%h c=%b e=%b code=%h want all zero", valid_o, pc_o, cancelled_o, exc_o, exccode_o); bad++;
        end
        resetn = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp, got_pc;
        logic        got_c;
        for (int i = 0; i < 4; i++) begin
            exp = 32'hbfc00000 + 32'(4 * i);
            drive(1, 1, (i > 0), 0, 32'h0, 0, 32'h0);
            total++; if (inst_req !== 1'b1) begin $display("FAIL stream_req[%0d] got=%b want=1", i, inst_req); bad++; end
            total++; if (inst_addr !== exp) begin $display("FAIL stream_addr[%0d] got=%h want=%h", i, inst_addr, exp); bad++; end
            sb_pc.push_back(exp); sb_canc.push_back(1'b0);
            tick();
            got_pc = sb_pc.pop_front(); got_c = sb_canc.pop_front();
            total++; if (valid_o !== 1'b1 || pc_o !== got_pc || cancelled_o !== got_c) begin
                $display("FAIL stream_slot[%0d] got v=%b pc=%h c=%b want v=1 pc=%h c=%b", i, valid_o, pc_o, cancelled_o, got_pc, got_c); bad++;
            end
        end
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_hold_redirect();
        logic [31:0] got_pc;
        logic        got_c;
        for (int c = 0; c < 3; c++) begin
            drive(1, 0, 0, (c == 1), 32'h80001000, 0, 32'h0);
            total++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin
                $display("FAIL hold_addr[%0d] got req=%b addr=%h want req=1 addr=bfc00010", c, inst_req, inst_addr); bad++;
            end
            tick();
        end
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00010) begin
            $display("FAIL hold_accept got req=%b addr=%h want req=1 addr=bfc00010", inst_req, inst_addr); bad++;
        end
        sb_pc.push_back(32'hbfc00010); sb_canc.push_back(1'b1);
        tick();
        got_pc = sb_pc.pop_front(); got_c = sb_canc.pop_front();
        total++; if (valid_o !== 1'b1 || pc_o !== got_pc || cancelled_o !== got_c) begin
            $display("FAIL hold_slot got v=%b pc=%h c=%b want v=1 pc=%h c=%b", valid_o, pc_o, cancelled_o, got_pc, got_c); bad++;
        end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'h80001000) begin
            $display("FAIL hold_target got req=%b addr=%h want req=1 addr=80001000", inst_req, inst_addr); bad++;
        end
        sb_pc.push_back(32'h80001000); sb_canc.push_back(1'b0);
        tick();
        got_pc = sb_pc.pop_front(); got_c = sb_canc.pop_front();
        total++; if (pc_o !== got_pc || cancelled_o !== got_c) begin
            $display("FAIL target_slot got pc=%h c=%b want pc=%h c=%b", pc_o, cancelled_o, got_pc, got_c); bad++;
        end
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_outstanding();
        logic [6:0]  exp_req = 7'b0100011;
        logic [31:0] exp_pc  = 32'h80001004;
        logic [31:0] got_pc;
        logic        got_c;
        int          hs_cnt  = 0;
        for (int c = 0; c < 7; c++) begin
            drive(1, 1, (c == 4), 0, 32'h0, 0, 32'h0);
            total++; if (inst_req !== exp_req[c]) begin $display("FAIL outst_req[%0d] got=%b want=%b", c, inst_req, exp_req[c]); bad++; end
            if (inst_req && inst_addr_ok) hs_cnt++;
            if (exp_req[c]) begin sb_pc.push_back(exp_pc); sb_canc.push_back(1'b0); exp_pc = exp_pc + 32'd4; end
            tick();
            if (exp_req[c]) begin
                got_pc = sb_pc.pop_front(); got_c = sb_canc.pop_front();
                total++; if (valid_o !== 1'b1 || pc_o !== got_pc || cancelled_o !== got_c) begin
                    $display("FAIL outst_slot[%0d] got v=%b pc=%h want v=1 pc=%h", c, valid_o, pc_o, got_pc); bad++;
                end
            end
        end
        total++; if (hs_cnt != 3) begin $display("FAIL outst_count got=%0d want=3", hs_cnt); bad++; end
        total++; if (valid_o !== 1'b0) begin $display("FAIL outst_bubble got=%b want=0", valid_o); bad++; end
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0); tick();
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0); tick();
    endtask

    task automatic test_misaligned();
        drive(1, 0, 0, 1, 32'h80000002, 0, 32'h0);
        total++; if (inst_req !== 1'b0) begin $display("FAIL mis_redirect_req got=%b want=0", inst_req); bad++; end
        tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b0 || inst_addr !== 32'h80000002) begin
            $display("FAIL mis_noreq got req=%b addr=%h want req=0 addr=80000002", inst_req, inst_addr); bad++;
        end
        tick();
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h80000002 || exc_o !== 1'b1 || exccode_o !== 5'h04 || cancelled_o !== 1'b0) begin
            $display("FAIL mis_slot got v=%b pc=%h e=%b code=%h c=%b want v=1 pc=80000002 e=1 code=04 c=0", valid_o, pc_o, exc_o, exccode_o, cancelled_o); bad++;
        end
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
            total++; if (inst_req !== 1'b0) begin $display("FAIL exc_wait_req[%0d] got=%b want=0", c, inst_req); bad++; end
            tick();
        end
        total++; if (valid_o !== 1'b0) begin $display("FAIL exc_taken got v=%b want=0", valid_o); bad++; end
        drive(1, 1, 0, 0, 32'h0, 1, 32'h80000380);
        total++; if (inst_req !== 1'b0) begin $display("FAIL eret_req got=%b want=0", inst_req); bad++; end
        tick();
        total++; if (exc_o !== 1'b0 || exccode_o !== 5'h0) begin $display("FAIL eret_clear got e=%b code=%h want 0/00", exc_o, exccode_o); bad++; end
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'h80000380) begin
            $display("FAIL eret_resume got req=%b addr=%h want req=1 addr=80000380", inst_req, inst_addr); bad++;
        end
        tick();
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h80000380 || exc_o !== 1'b0) begin
            $display("FAIL eret_slot got v=%b pc=%h e=%b want v=1 pc=80000380 e=0", valid_o, pc_o, exc_o); bad++;
        end
    endtask

    task automatic test_both_redirect();
        drive(1, 1, 1, 1, 32'h80001000, 1, 32'h80000380);
        total++; if (inst_req !== 1'b0) begin $display("FAIL both_req got=%b want=0", inst_req); bad++; end
        tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'h80000380) begin
            $display("FAIL both_addr got req=%b addr=%h want req=1 addr=80000380", inst_req, inst_addr); bad++;
        end
        tick();
    endtask

    task automatic test_wrap();
        drive(1, 0, 1, 1, 32'hfffffffc, 0, 32'h0);
        tick();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_addr !== 32'hfffffffc) begin $display("FAIL wrap_top got=%h want=fffffffc", inst_addr); bad++; end
        tick();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
            $display("FAIL wrap_zero got req=%b addr=%h want req=1 addr=00000000", inst_req, inst_addr); bad++;
        end
        tick();
        total++; if (pc_o !== 32'h0 || valid_o !== 1'b1) begin $display("FAIL wrap_slot got v=%b pc=%h want v=1 pc=00000000", valid_o, pc_o); bad++; end
        drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
        tick();
    endtask

    task automatic test_stall();
        for (int c = 0; c < 4; c++) begin
            drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
            total++; if (inst_req !== 1'b0 || inst_addr !== 32'h4) begin
                $display("FAIL stall_req[%0d] got req=%b addr=%h want req=0 addr=00000004", c, inst_req, inst_addr); bad++;
            end
            tick();
            total++; if (valid_o !== 1'b1 || pc_o !== 32'h0) begin
                $display("FAIL stall_hold[%0d] got v=%b pc=%h want v=1 pc=00000000", c, valid_o, pc_o); bad++;
            end
        end
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'h4) begin
            $display("FAIL stall_resume got req=%b addr=%h want req=1 addr=00000004", inst_req, inst_addr); bad++;
        end
        tick();
        drive(0, 0, 1, 1, 32'h80001000, 0, 32'h0);
        tick();
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h4 || cancelled_o !== 1'b1) begin
            $display("FAIL held_cancel got v=%b pc=%h c=%b want v=1 pc=00000004 c=1", valid_o, pc_o, cancelled_o); bad++;
        end
    endtask

    task automatic test_reset_in_hold();
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'h80001000) begin
            $display("FAIL rh_enter got req=%b addr=%h want req=1 addr=80001000", inst_req, inst_addr); bad++;
        end
        tick();
        drive(1, 0, 0, 1, 32'h80002000, 0, 32'h0);
        tick();
        resetn = 1'b0;
        drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b0) begin $display("FAIL rh_req got=%b want=0", inst_req); bad++; end
        tick();
        total++; if (valid_o !== 1'b0 || pc_o !== 32'h0 || cancelled_o !== 1'b0 || exc_o !== 1'b0 || exccode_o !== 5'h0 || inst_addr !== 32'hbfc00000) begin
            $display("FAIL rh_state got v=%b pc=%h c=%b e=%b addr=%h want 0/0/0/0 addr=bfc00000", valid_o, pc_o, cancelled_o, exc_o, inst_addr); bad++;
        end
        resetn = 1'b1;
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
        total++; if (inst_req !== 1'b1 || inst_addr !== 32'hbfc00000) begin
            $display("FAIL rh_restart got req=%b addr=%h want req=1 addr=bfc00000", inst_req, inst_addr); bad++;
        end
        tick();
        total++; if (valid_o !== 1'b1 || pc_o !== 32'hbfc00000 || cancelled_o !== 1'b0) begin
            $display("FAIL rh_slot got v=%b pc=%h c=%b want v=1 pc=bfc00000 c=0", valid_o, pc_o, cancelled_o); bad++;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold_redirect();
        test_outstanding();
        test_misaligned();
        test_both_redirect();
        test_wrap();
        test_stall();
        test_reset_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
